// File: rtl/pcm_rom_cache_if.sv
// Request and SDRAM bus between an ADPCM engine, its PCM ROM cache and the SDRAM client.
// The master drives requests and SDRAM returns, and the slave (the cache) answers both sides.
interface pcm_rom_cache_if #(
    parameter int AW = 20
);
    logic          FLUSH;
    logic [AW-1:0] REQ_ADDR;
    logic [7:0]    REQ_DATA;
    logic          REQ_OK;
    logic          SDRAM_CS;
    logic [AW-3:0] SDRAM_ADDR;
    logic [31:0]   SDRAM_DATA;
    logic          SDRAM_OK;

    modport master (
        output FLUSH, REQ_ADDR, SDRAM_DATA, SDRAM_OK,
        input  REQ_DATA, REQ_OK, SDRAM_CS, SDRAM_ADDR
    );

    modport slave (
        input  FLUSH, REQ_ADDR, SDRAM_DATA, SDRAM_OK,
        output REQ_DATA, REQ_OK, SDRAM_CS, SDRAM_ADDR
    );
endinterface

// File: rtl/pcm_rom_cache.sv
// Direct-mapped 16x32-bit read cache turning byte PCM fetches into word SDRAM reads.
// Hit: REQ_OK 2 edges after an address change; miss: REQ_OK on the SDRAM_OK edge, and SDRAM_CS is held until acknowledged.
module pcm_rom_cache #(
    parameter int AW = 20,
    parameter int LW = 4
) (
    input  logic            CLK96,
    input  logic            RESET96,
    pcm_rom_cache_if.slave  bus
);
    localparam int NL = 1 << LW;
    localparam int TW = AW - 2 - LW;

    typedef enum logic [1:0] {IDLE, LOOKUP, FETCH} state_t;

    state_t        state;
    logic [AW-1:0] a_l;
    logic [NL-1:0] valid;
    logic [NL-1:0] valid_nxt;
    logic          discard;
    logic [7:0]    req_data;
    logic          req_ok;
    logic          sdram_cs;
    logic [AW-3:0] sdram_addr;

    logic [31:0]   line_dat [NL];
    logic [TW-1:0] line_tag [NL];

    logic [LW-1:0] idx;
    logic [TW-1:0] tag;
    logic [LW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic          addr_chg;
    logic          fill;
    logic          own_word;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

    assign idx      = a_l[LW+1:2];
    assign tag      = a_l[AW-1:LW+2];
    assign fill_idx = sdram_addr[LW-1:0];
    assign fill_tag = sdram_addr[AW-3:LW];
    assign hit      = valid[idx] && (line_tag[idx] == tag);
    assign addr_chg = bus.REQ_ADDR != a_l;
    assign fill     = (state == FETCH) && sdram_cs && bus.SDRAM_OK;
    assign own_word = a_l[AW-1:2] == sdram_addr;

    assign bus.REQ_DATA   = req_data;
    assign bus.REQ_OK     = req_ok;
    assign bus.SDRAM_CS   = sdram_cs;
    assign bus.SDRAM_ADDR = sdram_addr;

    // A fill always overwrites its line, so its valid bit follows the discard flag; flush wins over everything.
    always_comb begin
        valid_nxt = valid;
        if (fill)
            valid_nxt[fill_idx] = !discard;
        if (bus.FLUSH)
            valid_nxt = '0;
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state      <= LOOKUP;
            a_l        <= '0;
            valid      <= '0;
            discard    <= 1'b0;
            req_data   <= '0;
            req_ok     <= 1'b0;
            sdram_cs   <= 1'b0;
            sdram_addr <= '0;
        end else begin
            valid <= valid_nxt;
            if (addr_chg) begin
                a_l    <= bus.REQ_ADDR;
                req_ok <= 1'b0;
            end
            if (bus.FLUSH)
                req_ok <= 1'b0;

            case (state)
                IDLE: begin
                    if (addr_chg || bus.FLUSH)
                        state <= LOOKUP;
                end
                LOOKUP: begin
                    // A moving address or a flush makes this lookup stale; retry next edge.
                    if (!addr_chg && !bus.FLUSH) begin
                        if (hit) begin
                            req_data <= sel_byte(line_dat[idx], a_l[1:0]);
                            req_ok   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            sdram_cs   <= 1'b1;
                            sdram_addr <= a_l[AW-1:2];
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fill) begin
                        sdram_cs <= 1'b0;
                        discard  <= 1'b0;
                        if (!addr_chg && !bus.FLUSH && !discard && own_word) begin
                            req_data <= sel_byte(bus.SDRAM_DATA, a_l[1:0]);
                            req_ok   <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= LOOKUP;
                        end
                    end else if (bus.FLUSH) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= LOOKUP;
            endcase
        end
    end

    always_ff @(posedge CLK96) begin
        if (fill && !RESET96) begin
            line_dat[fill_idx] <= bus.SDRAM_DATA;
            line_tag[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: doc/pcm_rom_cache.md
Name: pcm_rom_cache

Overview:
- Small direct-mapped read cache between an ADPCM voice's byte-wide PCM ROM port (jt6295 rom_addr/rom_data/rom_ok) and the 32-bit SDRAM PCM client.
- One instance per ADPCM engine, downstream of the sound block's PCM_ADDR/PCM_CS/PCM_DOUT/PCM_OK path.
- Absorbs the engine's sequential nibble fetches so SDRAM sees one request per 4 bytes.
- A FLUSH input invalidates the cache when upstream banking (NMK112 page registers, OKI bank select) remaps addresses without changing the request address.

Parameters:
- AW, 20, byte address width of the PCM request.
- LW, 4, log2 of cache line count (16 lines of 32 bits).

Ports:
- CLK96  in  1  system audio clock; all logic on rising edge.
- RESET96  in  1  synchronous, active-high reset.
- FLUSH  in  1  one-cycle pulse: invalidate all lines.
- REQ_ADDR  in  AW  byte address from ADPCM engine.
- REQ_DATA  out  8  byte returned for REQ_ADDR.
- REQ_OK  out  1  REQ_DATA valid for current REQ_ADDR.
- SDRAM_CS  out  1  SDRAM read request, held until SDRAM_OK.
- SDRAM_ADDR  out  AW-2  32-bit word address (REQ_ADDR[AW-1:2]).
- SDRAM_DATA  in  32  word from SDRAM, little-endian (byte0 = [7:0]).
- SDRAM_OK  in  1  SDRAM_DATA valid for SDRAM_ADDR while SDRAM_CS high.

Behaviour:
- Storage:
  - LW-bit index = a_l[LW+1:2]; tag = a_l[AW-1:LW+2]; byte select = a_l[1:0].
  - Data, tag and valid per line; valid is a register vector so it clears in one cycle.
- Reset values: REQ_OK=0, REQ_DATA=0, SDRAM_CS=0, SDRAM_ADDR=0, all valid=0, a_l=0, state=LOOKUP.
- Reset mid-fetch: SDRAM_CS drops on the next edge; a late SDRAM_OK is ignored.
- States IDLE, LOOKUP, FETCH. The same address-change check below is applied in IDLE, LOOKUP and FETCH:
  - REQ_ADDR != a_l: a_l<=REQ_ADDR; REQ_OK<=0 on the same edge.
- IDLE:
  - Address change: go LOOKUP.
  - FLUSH: clear valid, REQ_OK<=0, go LOOKUP.
- LOOKUP:
  - Hit (valid[index] && tag match): REQ_DATA<=selected byte, REQ_OK<=1, go IDLE.
  - Hit latency: REQ_OK high on the 2nd edge after REQ_ADDR changes.
  - Miss: SDRAM_CS<=1, SDRAM_ADDR<=a_l[AW-1:2], go FETCH.
  - Address change while in LOOKUP: re-evaluate with the new a_l; no OK for the stale address.
- FETCH:
  - SDRAM_CS and SDRAM_ADDR held stable until SDRAM_OK. Requests are never aborted.
  - On SDRAM_OK: SDRAM_CS<=0; line[index of SDRAM_ADDR]<=SDRAM_DATA; tag written; valid set unless a FLUSH arrived during this FETCH.
  - If a_l is unchanged and no flush arrived: REQ_DATA<=byte, REQ_OK<=1, go IDLE.
  - Otherwise go LOOKUP.
  - Miss latency: REQ_OK on the same edge that samples SDRAM_OK.
  - FLUSH during FETCH: valid cleared immediately, a discard flag is set, the fill is stored but not validated, then LOOKUP re-fetches.
  - Address change during FETCH: a_l updates, the fill completes normally (validated), then LOOKUP on the new address.
- Simultaneous FLUSH and address change: both take effect; result is LOOKUP on the new address with all lines invalid.
- Simultaneous FLUSH and SDRAM_OK: treated as FLUSH during FETCH (fill not validated).
- SDRAM_OK while SDRAM_CS=0: ignored.
- REQ_OK never asserts for an address other than the current a_l. REQ_DATA is stable while REQ_OK=1.
- Address wrap: no special case; SDRAM_ADDR is the truncated word address.

Test Plan:
- Reset → REQ_OK=0, SDRAM_CS=0. Release with REQ_ADDR=0 → SDRAM_CS=1, SDRAM_ADDR=0. SDRAM_OK with SDRAM_DATA=0x44332211 → REQ_DATA=0x11, REQ_OK=1 on that edge.
- Step REQ_ADDR through 0x00001..0x00003 after that fill → no SDRAM_CS. REQ_DATA 0x22, 0x33, 0x44, each with REQ_OK 2 cycles after the change.
- REQ_ADDR=0x00040 (same index 0, new tag) → miss, SDRAM_ADDR=0x10. Then REQ_ADDR=0x00000 → miss again (evicted).
- FLUSH pulse while idle on a cached address → REQ_OK drops next cycle, SDRAM_CS reasserts with the same SDRAM_ADDR, new data returned.
- Change REQ_ADDR 0x00100→0x00200 while SDRAM_CS is pending with 5-cycle OK delay → SDRAM_CS held; after OK, line for 0x100 valid, REQ_OK stays 0, new fetch SDRAM_ADDR=0x80, then OK with 0x200 data.
- FLUSH coincident with SDRAM_OK → REQ_OK stays 0, the same word is re-fetched, and a later access to it still misses until refilled.
